sha256d_nonce_sched: RTL and testbench

- Sequencer that drives one external sha256_module instance to compute double SHA-256 over an 80-byte block header.
- Sweeps a 32-bit nonce range and compares each final digest against a 256-bit target.
- Sits between the host-visible job registers and the hash core. It owns the core's reset, start and data_in for the whole job.

---
 rtl/sha256d_nonce_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_sha256d_nonce_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256d_nonce_sched.sv
// Double SHA-256 nonce sweep sequencer.
//
// Drives one external SHA-256 core through three compressions per nonce:
// header block 1 (from IV), header block 2 (chained, carries the nonce),
// then a fresh hash of the 256-bit first-pass digest. Each final digest is
// compared against the job target; the sweep stops on the first digest
// below target, on reaching nonce_end, on abort, or on a core timeout.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   job_start, job_abort     job control (start accepted only when idle)
//   header, target           job data; header word 19 (nonce slot) is unused
//   nonce_start, nonce_end   inclusive nonce range, wraps through zero
//   core_rst/start/data      control and message block to the hash core
//   core_digest, core_done   result and completion pulse from the hash core
//   busy, done               job in progress, 1-cycle end-of-job pulse
//   found, found_nonce,      sticky golden-nonce flag, its nonce and digest
//   hash_out
//   nonce_cur                nonce currently being hashed
//   error                    sticky watchdog-expiry flag
module sha256d_nonce_sched #(
    parameter int unsigned WAIT_MAX = 127
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_start,
    input  logic         job_abort,
    input  logic [639:0] header,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         core_rst,
    output logic         core_start,
    output logic [511:0] core_data,
    input  logic [255:0] core_digest,
    input  logic         core_done,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] hash_out,
    output logic [31:0]  nonce_cur,
    output logic         error
);

    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        StIdle,
        StRst1,
        StB1Go,
        StB1Wait,
        StB1Settle,
        StB2Rew,
        StB2Go,
        StB2Wait,
        StB2Cap,
        StRst2,
        StB3Go,
        StB3Wait,
        StB3Settle,
        StCheck
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wd_q, wd_d, wd_next;
    logic [607:0]    header_q, header_d;
    logic [255:0]    target_q, target_d;
    logic [31:0]     nonce_end_q, nonce_end_d;
    logic [31:0]     nonce_cur_q, nonce_cur_d;
    logic [255:0]    digest1_q, digest1_d;
    logic            done_q, done_d;
    logic            found_q, found_d;
    logic [31:0]     found_nonce_q, found_nonce_d;
    logic [255:0]    hash_out_q, hash_out_d;
    logic            error_q, error_d;
    logic            rst_pulse_q, rst_pulse_d;
    logic [511:0]    blk2, blk3;
    logic            unused_nonce_word;

    // The nonce slot of the header is replaced by nonce_cur.
    assign unused_nonce_word = ^header[639:608];

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        header_d      = header_q;
        target_d      = target_q;
        nonce_end_d   = nonce_end_q;
        nonce_cur_d   = nonce_cur_q;
        digest1_d     = digest1_q;
        done_d        = 1'b0;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        hash_out_d    = hash_out_q;
        error_d       = error_q;
        rst_pulse_d   = 1'b0;
        wd_next       = wd_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (job_start) begin
                    header_d    = header[607:0];
                    target_d    = target;
                    nonce_end_d = nonce_end;
                    nonce_cur_d = nonce_start;
                    found_d     = 1'b0;
                    error_d     = 1'b0;
                    state_d     = StRst1;
                end
            end
            StRst1:     state_d = StB1Go;
            StB1Go: begin
                wd_d    = '0;
                state_d = StB1Wait;
            end
            StB1Wait, StB2Wait, StB3Wait: begin
                if (core_done) begin
                    case (state_q)
                        StB1Wait: state_d = StB1Settle;
                        StB2Wait: state_d = StB2Cap;
                        default:  state_d = StB3Settle;
                    endcase
                end else if (wd_next == CntW'(WAIT_MAX)) begin
                    error_d     = 1'b1;
                    done_d      = 1'b1;
                    rst_pulse_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    wd_d = wd_next;
                end
            end
            StB1Settle: state_d = StB2Rew;
            // Chained block: first start cycle rewinds the core, second launches.
            StB2Rew: begin
                wd_d    = '0;
                state_d = StB2Go;
            end
            StB2Go: begin
                wd_d    = '0;
                state_d = StB2Wait;
            end
            StB2Cap: begin
                digest1_d = core_digest;
                state_d   = StRst2;
            end
            StRst2:     state_d = StB3Go;
            StB3Go: begin
                wd_d    = '0;
                state_d = StB3Wait;
            end
            StB3Settle: state_d = StCheck;
            StCheck: begin
                if (core_digest < target_q) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_cur_q;
                    hash_out_d    = core_digest;
                    done_d        = 1'b1;
                    state_d       = StIdle;
                end else if (nonce_cur_q == nonce_end_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    nonce_cur_d = nonce_cur_q + 32'd1;
                    state_d     = StRst1;
                end
            end
            default:    state_d = StIdle;
        endcase

        // Abort overrides every transition and leaves job results untouched.
        if (job_abort) begin
            state_d       = StIdle;
            rst_pulse_d   = 1'b1;
            done_d        = 1'b0;
            found_d       = found_q;
            found_nonce_d = found_nonce_q;
            hash_out_d    = hash_out_q;
            error_d       = error_q;
            nonce_cur_d   = nonce_cur_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wd_q          <= '0;
            header_q      <= '0;
            target_q      <= '0;
            nonce_end_q   <= '0;
            nonce_cur_q   <= '0;
            digest1_q     <= '0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            hash_out_q    <= '0;
            error_q       <= 1'b0;
            rst_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            header_q      <= header_d;
            target_q      <= target_d;
            nonce_end_q   <= nonce_end_d;
            nonce_cur_q   <= nonce_cur_d;
            digest1_q     <= digest1_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            hash_out_q    <= hash_out_d;
            error_q       <= error_d;
            rst_pulse_q   <= rst_pulse_d;
        end
    end

    // Message blocks; word w occupies bits [32w +: 32].
    always_comb begin
        blk2 = {32'h0000_0280, 320'd0, 32'h8000_0000, nonce_cur_q, header_q[607:512]};
        blk3 = '0;
        for (int w = 0; w < 8; w++) begin
            blk3[32*w +: 32] = digest1_q[255-32*w -: 32];
        end
        blk3[287:256] = 32'h8000_0000;
        blk3[511:480] = 32'h0000_0100;

        case (state_q)
            StRst1, StB1Go, StB1Wait:                     core_data = header_q[511:0];
            StB1Settle, StB2Rew, StB2Go, StB2Wait, StB2Cap: core_data = blk2;
            StRst2, StB3Go, StB3Wait, StB3Settle, StCheck:  core_data = blk3;
            default:                                      core_data = '0;
        endcase
    end

    assign core_rst    = reset | rst_pulse_q | (state_q == StRst1) | (state_q == StRst2);
    assign core_start  = (state_q == StB1Go) | (state_q == StB2Rew) | (state_q == StB2Go) |
                         (state_q == StB3Go);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign hash_out    = hash_out_q;
    assign nonce_cur   = nonce_cur_q;
    assign error       = error_q;

endmodule

// File: tb/tb_sha256d_nonce_sched.sv
// Self-checking bench for sha256d_nonce_sched. Contains a behavioural
// SHA-256 core (fixed latency, IV restore on reset, rewind-then-launch for
// chained blocks) and a job-level reference model computing SHA256d per nonce.
module tb_sha256d_nonce_sched;

    localparam int unsigned WAIT_MAX = 127;
    localparam int LAT = 12;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         job_start;
    logic         job_abort;
    logic [639:0] header;
    logic [255:0] target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic         core_rst;
    logic         core_start;
    logic [511:0] core_data;
    logic [255:0] core_digest;
    logic         core_done;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] hash_out;
    logic [31:0]  nonce_cur;
    logic         error;

    always #5 clk = ~clk;

    sha256d_nonce_sched #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .job_start  (job_start),
        .job_abort  (job_abort),
        .header     (header),
        .target     (target),
        .nonce_start(nonce_start),
        .nonce_end  (nonce_end),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_data  (core_data),
        .core_digest(core_digest),
        .core_done  (core_done),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .found_nonce(found_nonce),
        .hash_out   (hash_out),
        .nonce_cur  (nonce_cur),
        .error      (error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- SHA-256 arithmetic ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96], f + hin[95:64], g + hin[63:32], h + hin[31:0]};
    endfunction

    function automatic logic [511:0] pack(input logic [31:0] w [16]);
        logic [511:0] blk;
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = w[i];
        return blk;
    endfunction

    // Reference: SHA256d of the 80-byte header with word 19 replaced by nonce.
    function automatic logic [255:0] sha256d(input logic [639:0] hdr, input logic [31:0] nonce);
        logic [31:0]  w [16];
        logic [255:0] h1, h2;
        for (int i = 0; i < 16; i++) w[i] = hdr[32*i +: 32];
        h1 = compress(IV, pack(w));
        for (int i = 0; i < 16; i++) w[i] = 32'd0;
        for (int i = 0; i < 3; i++) w[i] = hdr[32*(16+i) +: 32];
        w[3] = nonce; w[4] = 32'h8000_0000; w[15] = 32'h0000_0280;
        h2 = compress(h1, pack(w));
        for (int i = 0; i < 16; i++) w[i] = 32'd0;
        for (int i = 0; i < 8; i++) w[i] = h2[255-32*i -: 32];
        w[8] = 32'h8000_0000; w[15] = 32'h0000_0100;
        return compress(IV, pack(w));
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] hdr;
        for (int i = 0; i < 20; i++) hdr[32*i +: 32] = $urandom;
        return hdr;
    endfunction

    // ---------------- Behavioural hash core ----------------
    int           cyc = 0;
    int           proto_err = 0;
    bit           core_mute = 1'b0;
    logic [255:0] m_h = IV, m_res = '0, m_digest = '0;
    logic [511:0] m_data = '0, m_rew_data = '0;
    logic         m_fresh = 1'b1, m_rew = 1'b0, m_busy = 1'b0;
    int           m_rem = 0;
    logic [31:0]  b2_n [$];
    int           b2_c [$];

    assign core_done   = m_busy && (m_rem == 0) && !core_mute;
    assign core_digest = m_digest;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (core_rst) begin
            m_h <= IV; m_fresh <= 1'b1; m_rew <= 1'b0; m_busy <= 1'b0; m_rem <= 0;
        end else if (m_busy) begin
            if (core_data != m_data || core_start) proto_err <= proto_err + 1;
            if (core_done) begin
                m_busy <= 1'b0; m_digest <= m_res; m_h <= m_res;
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
            end
        end else if (core_start) begin
            if (m_fresh || m_rew) begin
                if (m_rew && core_data != m_rew_data) proto_err <= proto_err + 1;
                m_res    <= compress(m_fresh ? IV : m_h, core_data);
                m_data   <= core_data;
                m_busy   <= 1'b1;
                m_rem    <= LAT - 1;
                m_fresh  <= 1'b0;
                m_rew    <= 1'b0;
                m_digest <= {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
                if (m_rew) begin
                    b2_n.push_back(core_data[127:96]);
                    b2_c.push_back(cyc);
                end
            end else begin
                m_rew <= 1'b1; m_rew_data <= core_data;
            end
        end else if (m_rew) begin
            proto_err <= proto_err + 1;
        end
    end

    // ---------------- Job-level tasks ----------------
    task automatic launch(input logic [639:0] hdr, input logic [255:0] tgt,
                          input logic [31:0] ns, input logic [31:0] ne);
        @(negedge clk);
        header = hdr; target = tgt; nonce_start = ns; nonce_end = ne; job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [639:0] hdr, input logic [255:0] tgt,
                           input logic [31:0] ns, input logic [31:0] ne);
        logic [31:0]  exp_q [$];
        logic [31:0]  n, exp_nonce;
        logic [255:0] h, exp_hash;
        bit           exp_found, got_done;
        int           base, pe0, budget, nst, ndn, g0;

        n = ns; exp_found = 1'b0; exp_nonce = '0; exp_hash = '0;
        for (int i = 0; i < 64; i++) begin
            h = sha256d(hdr, n);
            exp_q.push_back(n);
            if (h < tgt) begin
                exp_found = 1'b1; exp_nonce = n; exp_hash = h;
                break;
            end
            if (n == ne) break;
            n = n + 32'd1;
        end

        base = b2_n.size(); pe0 = proto_err;
        budget = 60 * (exp_q.size() + 2) + 50;
        launch(hdr, tgt, ns, ne);
        check_eq({tag, ":start_busy"}, busy, 1);
        check_eq({tag, ":start_nonce"}, nonce_cur, ns);
        check_eq({tag, ":start_flags"}, {found, error}, 0);

        got_done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin got_done = 1'b1; break; end
            // A start while busy must be ignored.
            job_start = (c == 20);
            if (c == 20) nonce_start = ns ^ 32'h5a5a_0000;
        end
        job_start = 1'b0;
        check_eq({tag, ":done_seen"}, got_done, 1);
        check_eq({tag, ":end_busy_err"}, {busy, error}, 0);
        check_eq({tag, ":found"}, found, exp_found);
        if (exp_found) begin
            check_eq({tag, ":found_nonce"}, found_nonce, exp_nonce);
            check_eq({tag, ":hash_out"}, hash_out, exp_hash);
        end
        check_eq({tag, ":n_visited"}, b2_n.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < b2_n.size(); i++)
            check_eq({tag, ":visit"}, b2_n[base+i], exp_q[i]);
        if (b2_n.size() - base >= 3) begin
            g0 = b2_c[base+1] - b2_c[base];
            for (int i = 2; i < b2_n.size() - base; i++)
                check_eq({tag, ":gap"}, b2_c[base+i] - b2_c[base+i-1], g0);
        end

        nst = 0; ndn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_start) nst++;
            if (done) ndn++;
        end
        check_eq({tag, ":no_start_after"}, nst, 0);
        check_eq({tag, ":done_pulse"}, ndn, 0);
        check_eq({tag, ":core_proto"}, proto_err, pe0);
    endtask

    task automatic run_watchdog();
        int k, ks, kd;
        core_mute = 1'b1;
        launch(rand_hdr(), '0, 32'h40, 32'h40);
        ks = -1; kd = -1; k = 1;
        for (int c = 0; c < 400; c++) begin
            if (core_start && ks < 0) ks = k;
            if (done) begin kd = k; break; end
            @(negedge clk);
            k++;
        end
        check_eq("wd:latency", kd - ks, WAIT_MAX + 1);
        check_eq("wd:err_busy_found", {error, busy, found}, 3'b100);
        check_eq("wd:core_rst", core_rst, 1);
        @(negedge clk);
        check_eq("wd:sticky", {error, done}, 2'b10);
        core_mute = 1'b0;
    endtask

    task automatic run_abort();
        int base, ndn;
        base = b2_n.size();
        launch(rand_hdr(), '0, 32'h20, 32'h2f);
        for (int c = 0; c < 200 && b2_n.size() == base; c++) @(negedge clk);
        check_eq("abort:reached_b2", b2_n.size() > base, 1);
        repeat (3) @(negedge clk);
        job_abort = 1'b1;
        @(negedge clk);
        job_abort = 1'b0;
        check_eq("abort:busy_rst_done", {busy, core_rst, done}, 3'b010);
        check_eq("abort:found", found, 0);
        @(negedge clk);
        check_eq("abort:rst_pulse", core_rst, 0);
        ndn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || core_start) ndn++;
        end
        check_eq("abort:quiet", ndn, 0);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        logic [639:0] hdr;
        logic [255:0] h7, tgt;
        logic [31:0]  ns;
        bit           ok, got_hdr;

        reset = 1'b1; job_start = 1'b0; job_abort = 1'b0;
        header = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clk);
        check_eq("rst:core_rst_high", core_rst, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst:flags", {busy, done, found, error, core_rst, core_start}, 0);
        check_eq("rst:core_data", core_data, 0);
        check_eq("rst:nonces", {found_nonce, nonce_cur}, 0);
        check_eq("rst:hash_out", hash_out, 0);

        run_job("single", rand_hdr(), {256{1'b1}}, 32'h5, 32'h5);
        check_eq("single:nonce5", found_nonce, 32'h5);
        run_job("sweep", rand_hdr(), '0, 32'h10, 32'h13);
        check_eq("sweep:last_nonce", nonce_cur, 32'h13);

        got_hdr = 1'b0; hdr = '0; h7 = '0;
        for (int t = 0; t < 400 && !got_hdr; t++) begin
            hdr = rand_hdr(); h7 = sha256d(hdr, 32'h7); ok = 1'b1;
            for (int n = 0; n < 16; n++)
                if (n != 7 && sha256d(hdr, n[31:0]) <= h7) ok = 1'b0;
            got_hdr = ok;
        end
        check_eq("golden:hdr_search", got_hdr, 1);
        run_job("golden", hdr, h7 + 256'd1, 32'h0, 32'hf);
        check_eq("golden:nonce7", found_nonce, 32'h7);

        run_job("wrap", rand_hdr(), '0, 32'hffff_fffe, 32'h0000_0001);

        run_watchdog();
        run_abort();
        run_job("post_abort", rand_hdr(), {4'h7, {252{1'b1}}}, 32'h100, 32'h103);

        for (int i = 0; i < 8; i++) begin
            ns  = (i % 3 == 0) ? 32'hffff_ffff - $urandom_range(0, 3) : $urandom;
            tgt = {$urandom >> $urandom_range(0, 6), $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            run_job("rand", rand_hdr(), tgt, ns, ns + $urandom_range(0, 5));
        end

        launch(rand_hdr(), {256{1'b1}}, 32'h9, 32'h9);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst:state", {busy, done, found, error, core_start}, 0);
        check_eq("midrst:regs", {found_nonce, nonce_cur, hash_out, core_data}, 0);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || busy) ok = 1'b1;
        end
        check_eq("midrst:quiet", ok, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
